thread_state_mgr: RTL and testbench
===================================

# thread_state_mgr

Owns the per-thread state word of every thread in a sha512unit and is the writer side of the thread-state read port that the CPU thread scheduler polls for `THREAD_STATE_WR_RDY`. It takes state transitions from three agents (input loader, CPU, output unloader) and applies them to one register per thread. It exposes a registered random-access read port and registered "find first" results, so the loader locates an empty thread and the unloader locates a finished one.

## Interface
Parameters:
- N_CORES, 4, number of cores in the unit
- N_THREADS, 4*N_CORES, threads held
- N_THREADS_MSB, `MSB(N_THREADS-1), thread-number MSB

Ports:
- CLK  in  1  single clock
- RST_N  in  1  asynchronous, active-low reset
- ts_rd_num  in  N_THREADS_MSB+1  scheduler read address
- ts_rd  out  2  state of ts_rd_num, registered
- ld_num  in  N_THREADS_MSB+1  loader thread
- ld_start  in  1  loader claims thread: NONE->BUSY
- ld_done  in  1  loader finished: BUSY->WR_RDY
- cpu_num  in  N_THREADS_MSB+1  CPU thread
- cpu_wr_en  in  1  CPU writes cpu_state
- cpu_state  in  2  new state from CPU (RD_RDY or WR_RDY)
- ul_num  in  N_THREADS_MSB+1  unloader thread
- ul_start  in  1  unloader claims: RD_RDY->BUSY
- ul_done  in  1  unloader finished: BUSY->NONE
- none_found  out  1  some thread is NONE
- none_num  out  N_THREADS_MSB+1  lowest-index NONE thread
- rd_rdy_found  out  1  some thread is RD_RDY
- rd_rdy_num  out  N_THREADS_MSB+1  lowest-index RD_RDY thread
- n_wr_rdy  out  N_THREADS_MSB+2  count of WR_RDY threads
- err  out  1  sticky illegal-transition flag

## Operation
- Encodings: NONE=2'b00, WR_RDY=2'b01, RD_RDY=2'b10, BUSY=2'b11.
- Storage: N_THREADS 2-bit registers, all NONE on reset.
- Per cycle, up to three writes apply, one per agent. Writes to different threads all apply in the same cycle.
- Same thread targeted by several agents: CPU wins, then unloader, then loader. Losing writes are dropped and set err when checking is enabled.
- ld_start and ld_done asserted together: ld_done wins. The same applies to ul_start and ul_done.
- Legal transitions:
  - ld_start: NONE->BUSY
  - ld_done: BUSY->WR_RDY
  - CPU: WR_RDY->RD_RDY or WR_RDY->WR_RDY
  - ul_start: RD_RDY->BUSY
  - ul_done: BUSY->NONE
- Out-of-range thread number (>= N_THREADS): write ignored, err set.
- Find logic: combinational priority encoders over the storage, registered once. When nothing is found, the corresponding `*_found` output is 0 and the `*_num` output is 0.
- n_wr_rdy: registered population count of WR_RDY threads, recomputed every cycle from the storage.

## Timing
- Write asserted in cycle N: storage updated at edge N+1.
- ts_rd, finds and n_wr_rdy reflect that storage at edge N+2. This matches the scheduler's 2-cycle same-thread hold-off.
- ts_rd read latency is 1 cycle from ts_rd_num.
- Reset values:
  - ts_rd=NONE, none_found=1, none_num=0
  - rd_rdy_found=0, rd_rdy_num=0, n_wr_rdy=0, err=0
- RST_N assertion mid-operation clears all state immediately. In-flight loader or unloader claims are lost.
- err clears only on reset.

## Configuration
- THREAD_STATE_CHECK_EN defined: transitions are validated against the legal list. Illegal or conflicting writes are dropped and err is set.
- THREAD_STATE_CHECK_EN undefined:
  - Each agent's write is applied unconditionally, subject only to priority.
  - ld_start forces BUSY, ld_done forces WR_RDY, ul_start forces BUSY, ul_done forces NONE, and the CPU writes cpu_state.
  - err is tied 0.

## Structure
- Shared package/header `sha512.vh` holds `THREAD_STATE_NONE`, `THREAD_STATE_WR_RDY`, `THREAD_STATE_RD_RDY`, `THREAD_STATE_BUSY`, `THREAD_STATE_MSB` and `MSB()`.
- One sub-module, `thread_state_find`: parameterised lowest-index match encoder with registered output. It is instantiated twice, once for NONE and once for RD_RDY.

## Test plan
- Reset, then read all threads: ts_rd=NONE everywhere, none_found=1, none_num=0, n_wr_rdy=0.
- ld_start on thread 3, then ld_done on thread 3: ts_rd(3)=BUSY, then WR_RDY two cycles after each write; n_wr_rdy=1.
- CPU writes RD_RDY to thread 3, ul_start, then ul_done: rd_rdy_found=1 with rd_rdy_num=3, then BUSY, then NONE; rd_rdy_found returns to 0.
- Same cycle: cpu_wr_en on thread 5 (WR_RDY->RD_RDY) and ul_start on thread 5: thread 5=RD_RDY and err=1 (with CHECK_EN).
- Fill all threads via the loader: none_found=0 after the last load, n_wr_rdy=N_THREADS. Then ld_start on full thread 0 with CHECK_EN: state unchanged, err=1.
- Pulse RST_N low while threads are BUSY: all states go to NONE immediately and err=0.

Source files
------------

// File: rtl/thread_state_mgr_pkg.sv
// Shared thread-state encodings and width helper for the sha512unit thread-state manager.
package thread_state_mgr_pkg;

  localparam int THREAD_STATE_MSB = 1;

  typedef enum logic [THREAD_STATE_MSB:0] {
    THREAD_STATE_NONE   = 2'b00,
    THREAD_STATE_WR_RDY = 2'b01,
    THREAD_STATE_RD_RDY = 2'b10,
    THREAD_STATE_BUSY   = 2'b11
  } thread_state_e;

  // Index of the highest set bit; msb(0) is 0 so a one-entry table still gets a 1-bit index.
  function automatic int msb(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/thread_state_find.sv
// Lowest-index match encoder over the packed thread-state table, registered once.
module thread_state_find
  import thread_state_mgr_pkg::*;
#(
  parameter int                        N_THREADS = 16,
  parameter int                        NUM_W     = 4,
  parameter logic [THREAD_STATE_MSB:0] MATCH     = THREAD_STATE_NONE,
  parameter logic                      FOUND_RST = 1'b0
) (
  input  logic                                       CLK,
  input  logic                                       RST_N,
  input  logic [N_THREADS-1:0][THREAD_STATE_MSB:0]   states,
  output logic                                       found,
  output logic [NUM_W-1:0]                           num
);

  logic             found_c;
  logic [NUM_W-1:0] num_c;
  logic             found_p2;
  logic [NUM_W-1:0] num_p2;

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    found_c = 1'b0;
    num_c   = '0;
    for (int t = N_THREADS - 1; t >= 0; t--) begin
      if (states[t] == MATCH) begin
        found_c = 1'b1;
        num_c   = NUM_W'(t);
      end
    end
  end

  // ---- stage p2: registered find result ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      found_p2 <= FOUND_RST;
      num_p2   <= '0;
    end else begin
      found_p2 <= found_c;
      num_p2   <= num_c;
    end
  end

  assign found = found_p2;
  assign num   = num_p2;

endmodule

// File: rtl/thread_state_mgr.sv
// Per-thread state words of a sha512unit: loader/CPU/unloader writes, scheduler read port,
// registered finds and WR_RDY count. Define THREAD_STATE_CHECK_EN to validate transitions and drive err.
module thread_state_mgr
  import thread_state_mgr_pkg::*;
#(
  parameter int N_CORES       = 4,
  parameter int N_THREADS     = 4 * N_CORES,
  parameter int N_THREADS_MSB = msb(N_THREADS - 1)
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [N_THREADS_MSB:0]      ts_rd_num,
  output logic [THREAD_STATE_MSB:0]   ts_rd,
  input  logic [N_THREADS_MSB:0]      ld_num,
  input  logic                        ld_start,
  input  logic                        ld_done,
  input  logic [N_THREADS_MSB:0]      cpu_num,
  input  logic                        cpu_wr_en,
  input  logic [THREAD_STATE_MSB:0]   cpu_state,
  input  logic [N_THREADS_MSB:0]      ul_num,
  input  logic                        ul_start,
  input  logic                        ul_done,
  output logic                        none_found,
  output logic [N_THREADS_MSB:0]      none_num,
  output logic                        rd_rdy_found,
  output logic [N_THREADS_MSB:0]      rd_rdy_num,
  output logic [N_THREADS_MSB+1:0]    n_wr_rdy,
  output logic                        err
);

  localparam int NUM_W = N_THREADS_MSB + 1;
  localparam int CNT_W = N_THREADS_MSB + 2;

  logic [N_THREADS-1:0][THREAD_STATE_MSB:0] state_p1;
  logic [N_THREADS-1:0][THREAD_STATE_MSB:0] state_d;

  logic                      ld_vld, ul_vld;
  logic                      ld_in, ul_in, cpu_in;
  logic                      ld_drop, ul_drop;
  logic [THREAD_STATE_MSB:0] ld_new, ul_new;
  logic                      ld_legal, ul_legal, cpu_legal;

  logic [THREAD_STATE_MSB:0] ts_rd_c, ts_rd_p2;
  logic [CNT_W-1:0]          n_wr_rdy_c, n_wr_rdy_p2;

  assign ld_vld = ld_start | ld_done;
  assign ul_vld = ul_start | ul_done;
  assign ld_in  = ld_vld    && (int'(ld_num)  < N_THREADS);
  assign ul_in  = ul_vld    && (int'(ul_num)  < N_THREADS);
  assign cpu_in = cpu_wr_en && (int'(cpu_num) < N_THREADS);

  // A done pulse overrides a start pulse from the same agent.
  assign ld_new = ld_done ? THREAD_STATE_WR_RDY : THREAD_STATE_BUSY;
  assign ul_new = ul_done ? THREAD_STATE_NONE   : THREAD_STATE_BUSY;

  // Arbitration looks only at the target thread: CPU, then unloader, then loader.
  assign ul_drop = ul_in && cpu_in && (ul_num == cpu_num);
  assign ld_drop = ld_in && ((cpu_in && (ld_num == cpu_num)) ||
                             (ul_in  && (ld_num == ul_num)));

`ifdef THREAD_STATE_CHECK_EN
  logic [THREAD_STATE_MSB:0] ld_req, ul_req;
  logic                      err_set;
  logic                      err_p1;

  assign ld_req = ld_done ? THREAD_STATE_BUSY : THREAD_STATE_NONE;
  assign ul_req = ul_done ? THREAD_STATE_BUSY : THREAD_STATE_RD_RDY;

  assign ld_legal  = (state_p1[ld_num] == ld_req);
  assign ul_legal  = (state_p1[ul_num] == ul_req);
  assign cpu_legal = (state_p1[cpu_num] == THREAD_STATE_WR_RDY) &&
                     ((cpu_state == THREAD_STATE_WR_RDY) || (cpu_state == THREAD_STATE_RD_RDY));

  assign err_set = (ld_vld    && !ld_in) ||
                   (ul_vld    && !ul_in) ||
                   (cpu_wr_en && !cpu_in) ||
                   ld_drop || ul_drop ||
                   (cpu_in && !cpu_legal) ||
                   (ul_in  && !ul_drop && !ul_legal) ||
                   (ld_in  && !ld_drop && !ld_legal);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_p1 <= 1'b0;
    else        err_p1 <= err_p1 | err_set;
  end

  assign err = err_p1;
`else
  assign ld_legal  = 1'b1;
  assign ul_legal  = 1'b1;
  assign cpu_legal = 1'b1;
  assign err       = 1'b0;
`endif

  // Surviving writes always target distinct threads, so their order here is irrelevant.
  always_comb begin
    state_d = state_p1;
    if (cpu_in && cpu_legal)            state_d[cpu_num] = cpu_state;
    if (ul_in && !ul_drop && ul_legal)  state_d[ul_num]  = ul_new;
    if (ld_in && !ld_drop && ld_legal)  state_d[ld_num]  = ld_new;
  end

  // ---- stage p1: thread-state storage ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_p1 <= '0;
    else        state_p1 <= state_d;
  end

  always_comb begin
    ts_rd_c    = (int'(ts_rd_num) < N_THREADS) ? state_p1[ts_rd_num] : THREAD_STATE_NONE;
    n_wr_rdy_c = '0;
    for (int t = 0; t < N_THREADS; t++) begin
      if (state_p1[t] == THREAD_STATE_WR_RDY) n_wr_rdy_c = n_wr_rdy_c + CNT_W'(1);
    end
  end

  // ---- stage p2: registered read port, finds and WR_RDY count ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ts_rd_p2    <= THREAD_STATE_NONE;
      n_wr_rdy_p2 <= '0;
    end else begin
      ts_rd_p2    <= ts_rd_c;
      n_wr_rdy_p2 <= n_wr_rdy_c;
    end
  end

  assign ts_rd    = ts_rd_p2;
  assign n_wr_rdy = n_wr_rdy_p2;

  thread_state_find #(
    .N_THREADS (N_THREADS),
    .NUM_W     (NUM_W),
    .MATCH     (THREAD_STATE_NONE),
    .FOUND_RST (1'b1)
  ) u_find_none (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .states (state_p1),
    .found  (none_found),
    .num    (none_num)
  );

  thread_state_find #(
    .N_THREADS (N_THREADS),
    .NUM_W     (NUM_W),
    .MATCH     (THREAD_STATE_RD_RDY),
    .FOUND_RST (1'b0)
  ) u_find_rd_rdy (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .states (state_p1),
    .found  (rd_rdy_found),
    .num    (rd_rdy_num)
  );

endmodule

// File: tb/tb_thread_state_mgr.sv
// Bench for thread_state_mgr: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_thread_state_mgr;

  localparam int N_CORES = 3;
  localparam int NT      = 4 * N_CORES;
  localparam int NW      = 4;
`ifdef THREAD_STATE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [1:0] S_NONE = 2'b00;
  localparam logic [1:0] S_WR   = 2'b01;
  localparam logic [1:0] S_RD   = 2'b10;
  localparam logic [1:0] S_BUSY = 2'b11;
  localparam logic [NW:0] NT_CNT = NT;

  localparam int OP_LD_START = 0;
  localparam int OP_LD_DONE  = 1;
  localparam int OP_UL_START = 2;
  localparam int OP_UL_DONE  = 3;
  localparam int OP_CPU      = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [NW-1:0] ts_rd_num, ld_num, cpu_num, ul_num, none_num, rd_rdy_num;
  logic [1:0]    ts_rd, cpu_state;
  logic          ld_start, ld_done, cpu_wr_en, ul_start, ul_done;
  logic          none_found, rd_rdy_found, err;
  logic [NW:0]   n_wr_rdy;

  int checks = 0;
  int errors = 0;

  // Behavioural model: state per thread, sticky error, expected registered outputs.
  int mst[NT];
  bit claimed[NT];
  bit merr;
  int e_ts, e_nf, e_nn, e_rf, e_rn, e_cnt;

  thread_state_mgr #(.N_CORES(N_CORES)) dut (
    .CLK(CLK), .RST_N(RST_N), .ts_rd_num(ts_rd_num), .ts_rd(ts_rd),
    .ld_num(ld_num), .ld_start(ld_start), .ld_done(ld_done),
    .cpu_num(cpu_num), .cpu_wr_en(cpu_wr_en), .cpu_state(cpu_state),
    .ul_num(ul_num), .ul_start(ul_start), .ul_done(ul_done),
    .none_found(none_found), .none_num(none_num),
    .rd_rdy_found(rd_rdy_found), .rd_rdy_num(rd_rdy_num),
    .n_wr_rdy(n_wr_rdy), .err(err)
  );

  always #5 CLK = ~CLK;

  function automatic bit legal(int op, int cur, int nxt);
    case (op)
      OP_LD_START: return cur == S_NONE;
      OP_LD_DONE:  return cur == S_BUSY;
      OP_UL_START: return cur == S_RD;
      OP_UL_DONE:  return cur == S_BUSY;
      default:     return (cur == S_WR) && (nxt == S_WR || nxt == S_RD);
    endcase
  endfunction

  // Agents are offered the thread in priority order; the first to ask claims it.
  function automatic void model_write(int op, int num, int nxt);
    if (num >= NT) begin
      merr |= CHK;
      return;
    end
    if (claimed[num]) begin
      merr |= CHK;
      return;
    end
    claimed[num] = 1'b1;
    if (!CHK || legal(op, mst[num], nxt)) mst[num] = nxt;
    else merr = 1'b1;
  endfunction

  function automatic void model_edge();
    e_ts = (int'(ts_rd_num) < NT) ? mst[ts_rd_num] : 0;
    e_nf = 0; e_nn = 0; e_rf = 0; e_rn = 0; e_cnt = 0;
    for (int t = 0; t < NT; t++) begin
      if (mst[t] == S_NONE && e_nf == 0) begin e_nf = 1; e_nn = t; end
      if (mst[t] == S_RD && e_rf == 0)   begin e_rf = 1; e_rn = t; end
      if (mst[t] == S_WR) e_cnt++;
    end
    for (int t = 0; t < NT; t++) claimed[t] = 1'b0;
    if (cpu_wr_en) model_write(OP_CPU, int'(cpu_num), int'(cpu_state));
    if (ul_start || ul_done)
      model_write(ul_done ? OP_UL_DONE : OP_UL_START, int'(ul_num), ul_done ? S_NONE : S_BUSY);
    if (ld_start || ld_done)
      model_write(ld_done ? OP_LD_DONE : OP_LD_START, int'(ld_num), ld_done ? S_WR : S_BUSY);
  endfunction

  function automatic void model_reset();
    for (int t = 0; t < NT; t++) mst[t] = S_NONE;
    merr = 1'b0;
    e_ts = 0; e_nf = 1; e_nn = 0; e_rf = 0; e_rn = 0; e_cnt = 0;
  endfunction

  task automatic idle();
    ld_start = 0; ld_done = 0; cpu_wr_en = 0; ul_start = 0; ul_done = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    idle();
    RST_N = 1'b0;
    #2;
    RST_N = 1'b1;
    model_reset();
  endtask

  task automatic load(int t);
    ld_num = NW'(t); ld_start = 1; tick(); idle();
    ld_num = NW'(t); ld_done = 1;  tick(); idle();
  endtask

  task automatic test_reset();
    checks++; if (ts_rd !== S_NONE) begin errors++; $display("FAIL rst_ts_rd: got %0d expected %0d", ts_rd, S_NONE); end
    checks++; if (none_found !== 1'b1 || none_num !== '0) begin errors++; $display("FAIL rst_none: got %0d/%0d expected 1/0", none_found, none_num); end
    checks++; if (rd_rdy_found !== 1'b0 || rd_rdy_num !== '0) begin errors++; $display("FAIL rst_rd_rdy: got %0d/%0d expected 0/0", rd_rdy_found, rd_rdy_num); end
    checks++; if (n_wr_rdy !== '0 || err !== 1'b0) begin errors++; $display("FAIL rst_cnt_err: got %0d/%0d expected 0/0", n_wr_rdy, err); end
    for (int t = 0; t < NT; t++) begin
      ts_rd_num = NW'(t);
      tick();
      checks++; if (ts_rd !== S_NONE) begin errors++; $display("FAIL rst_read_%0d: got %0d expected %0d", t, ts_rd, S_NONE); end
    end
  endtask

  task automatic test_load();
    ts_rd_num = 3; ld_num = 3; ld_start = 1; tick(); idle();
    checks++; if (ts_rd !== S_NONE) begin errors++; $display("FAIL ld_start_lat1: got %0d expected %0d", ts_rd, S_NONE); end
    tick();
    checks++; if (ts_rd !== S_BUSY) begin errors++; $display("FAIL ld_start_busy: got %0d expected %0d", ts_rd, S_BUSY); end
    ld_num = 3; ld_done = 1; tick(); idle(); tick();
    checks++; if (ts_rd !== S_WR) begin errors++; $display("FAIL ld_done_wr: got %0d expected %0d", ts_rd, S_WR); end
    checks++; if (n_wr_rdy !== 5'd1) begin errors++; $display("FAIL ld_done_cnt: got %0d expected 1", n_wr_rdy); end
    checks++; if (none_found !== 1'b1 || none_num !== 4'd0) begin errors++; $display("FAIL ld_done_none: got %0d/%0d expected 1/0", none_found, none_num); end
  endtask

  task automatic test_cpu_unload();
    ts_rd_num = 3; cpu_num = 3; cpu_state = S_RD; cpu_wr_en = 1; tick(); idle(); tick();
    checks++; if (ts_rd !== S_RD) begin errors++; $display("FAIL cpu_rd: got %0d expected %0d", ts_rd, S_RD); end
    checks++; if (rd_rdy_found !== 1'b1 || rd_rdy_num !== 4'd3) begin errors++; $display("FAIL cpu_find_rd: got %0d/%0d expected 1/3", rd_rdy_found, rd_rdy_num); end
    checks++; if (n_wr_rdy !== 5'd0) begin errors++; $display("FAIL cpu_cnt: got %0d expected 0", n_wr_rdy); end
    ul_num = 3; ul_start = 1; tick(); idle(); tick();
    checks++; if (ts_rd !== S_BUSY || rd_rdy_found !== 1'b0) begin errors++; $display("FAIL ul_start: got %0d/%0d expected %0d/0", ts_rd, rd_rdy_found, S_BUSY); end
    ul_num = 3; ul_done = 1; tick(); idle(); tick();
    checks++; if (ts_rd !== S_NONE) begin errors++; $display("FAIL ul_done: got %0d expected %0d", ts_rd, S_NONE); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL legal_flow_err: got %0d expected 0", err); end
  endtask

  task automatic test_conflict();
    do_reset();
    ld_num = 13; ld_start = 1; tick(); idle();
    checks++; if (err !== CHK) begin errors++; $display("FAIL oor_err: got %0d expected %0d", err, CHK); end
    tick();
    checks++; if (none_num !== 4'd0 || n_wr_rdy !== 5'd0 || rd_rdy_found !== 1'b0) begin errors++; $display("FAIL oor_ignored: got %0d/%0d/%0d expected 0/0/0", none_num, n_wr_rdy, rd_rdy_found); end
    do_reset();
    load(5);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL pre_conflict_err: got %0d expected 0", err); end
    ts_rd_num = 5;
    cpu_num = 5; cpu_state = S_RD; cpu_wr_en = 1;
    ul_num = 5; ul_start = 1;
    ld_num = 6; ld_start = 1;
    tick(); idle();
    checks++; if (err !== CHK) begin errors++; $display("FAIL conflict_err: got %0d expected %0d", err, CHK); end
    tick();
    checks++; if (ts_rd !== S_RD || rd_rdy_num !== 4'd5) begin errors++; $display("FAIL conflict_cpu_wins: got %0d/%0d expected %0d/5", ts_rd, rd_rdy_num, S_RD); end
    ts_rd_num = 6; tick();
    checks++; if (ts_rd !== S_BUSY) begin errors++; $display("FAIL parallel_ld: got %0d expected %0d", ts_rd, S_BUSY); end
    ld_num = 6; ld_start = 1; ld_done = 1; tick(); idle(); tick();
    checks++; if (ts_rd !== S_WR) begin errors++; $display("FAIL ld_done_wins: got %0d expected %0d", ts_rd, S_WR); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int t = 0; t < NT; t++) load(t);
    tick();
    checks++; if (none_found !== 1'b0 || none_num !== 4'd0) begin errors++; $display("FAIL fill_none: got %0d/%0d expected 0/0", none_found, none_num); end
    checks++; if (n_wr_rdy !== NT_CNT || err !== 1'b0) begin errors++; $display("FAIL fill_cnt: got %0d/%0d expected %0d/0", n_wr_rdy, err, NT_CNT); end
    ts_rd_num = 0; ld_num = 0; ld_start = 1; tick(); idle();
    checks++; if (err !== CHK) begin errors++; $display("FAIL full_ld_err: got %0d expected %0d", err, CHK); end
    tick();
    checks++; if (ts_rd !== (CHK ? S_WR : S_BUSY)) begin errors++; $display("FAIL full_ld_state: got %0d expected %0d", ts_rd, CHK ? S_WR : S_BUSY); end
    checks++; if (n_wr_rdy !== (CHK ? NT_CNT : NT_CNT - 5'd1)) begin errors++; $display("FAIL full_ld_cnt: got %0d expected %0d", n_wr_rdy, CHK ? NT_CNT : NT_CNT - 5'd1); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int t = 0; t < 4; t++) begin ld_num = NW'(t); ld_start = 1; tick(); idle(); end
    ld_num = 9; ld_done = 1; tick(); idle(); tick();
    checks++; if (n_wr_rdy !== (CHK ? 5'd0 : 5'd1) || err !== CHK) begin errors++; $display("FAIL pre_reset: got %0d/%0d expected %0d/%0d", n_wr_rdy, err, CHK ? 0 : 1, CHK); end
    ts_rd_num = 1; tick();
    checks++; if (ts_rd !== S_BUSY) begin errors++; $display("FAIL pre_reset_busy: got %0d expected %0d", ts_rd, S_BUSY); end
    #2 RST_N = 1'b0;
    #1;
    checks++; if (ts_rd !== S_NONE || none_found !== 1'b1 || none_num !== 4'd0) begin errors++; $display("FAIL async_rst_rd: got %0d/%0d/%0d expected 0/1/0", ts_rd, none_found, none_num); end
    checks++; if (n_wr_rdy !== 5'd0 || err !== 1'b0 || rd_rdy_found !== 1'b0) begin errors++; $display("FAIL async_rst_cnt: got %0d/%0d/%0d expected 0/0/0", n_wr_rdy, err, rd_rdy_found); end
    RST_N = 1'b1;
    model_reset();
    for (int t = 0; t < 4; t++) begin
      ts_rd_num = NW'(t); tick();
      checks++; if (ts_rd !== S_NONE) begin errors++; $display("FAIL post_rst_read_%0d: got %0d expected %0d", t, ts_rd, S_NONE); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ts_rd_num = NW'($urandom_range(0, NT - 1));
      ld_num    = NW'($urandom_range(0, NT + 1));
      ld_start  = ($urandom_range(0, 2) == 0);
      ld_done   = ($urandom_range(0, 3) == 0);
      cpu_num   = NW'($urandom_range(0, NT));
      cpu_state = 2'($urandom_range(0, 3));
      cpu_wr_en = ($urandom_range(0, 3) == 0);
      ul_num    = NW'($urandom_range(0, NT + 1));
      ul_start  = ($urandom_range(0, 3) == 0);
      ul_done   = ($urandom_range(0, 3) == 0);
      tick();
      checks++; if (ts_rd !== 2'(e_ts)) begin errors++; $display("FAIL rnd_ts_rd @%0d: got %0d expected %0d", i, ts_rd, e_ts); end
      checks++; if (none_found !== 1'(e_nf) || none_num !== NW'(e_nn)) begin errors++; $display("FAIL rnd_none @%0d: got %0d/%0d expected %0d/%0d", i, none_found, none_num, e_nf, e_nn); end
      checks++; if (rd_rdy_found !== 1'(e_rf) || rd_rdy_num !== NW'(e_rn)) begin errors++; $display("FAIL rnd_rd_rdy @%0d: got %0d/%0d expected %0d/%0d", i, rd_rdy_found, rd_rdy_num, e_rf, e_rn); end
      checks++; if (n_wr_rdy !== (NW+1)'(e_cnt)) begin errors++; $display("FAIL rnd_cnt @%0d: got %0d expected %0d", i, n_wr_rdy, e_cnt); end
      checks++; if (err !== merr) begin errors++; $display("FAIL rnd_err @%0d: got %0d expected %0d", i, err, merr); end
    end
    idle();
  endtask

  initial begin
    idle();
    ts_rd_num = 0; ld_num = 0; cpu_num = 0; ul_num = 0; cpu_state = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    test_reset();
    test_load();
    test_cpu_unload();
    test_conflict();
    test_fill();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
